// File: rtl/buffer2sram_weight.sv
// buffer2sram_weight: copies a range of 288-bit kernel words from one weight
// ping-pong buffer into the banked weight SRAM, striping words round-robin.
`default_nettype none

module buffer2sram_weight #(
    parameter int NUM_BANKS = 32,
    parameter int DATA_W    = 288,
    parameter int ADDR_W    = 7
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_W-1:0]                   BUF_ADDR_start,
    input  logic [ADDR_W-1:0]                   BUF_ADDR_end,
    input  logic                                buf_select,
    input  logic [ADDR_W-1:0]                   SRAM_ADDR_start,
    input  logic [$clog2(NUM_BANKS)-1:0]        bank_start,
    input  logic                                buffer2sram_start,
    output logic                                buffer2sram_done,
    input  logic [1:0][DATA_W-1:0]              weight_buffer_DO,
    output logic [1:0][ADDR_W-1:0]              weight_buffer_A_read,
    output logic [1:0]                          weight_buffer_CEN_read,
    output logic [1:0]                          weight_buffer_OEN,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]    weight_SRAM_DI,
    output logic [NUM_BANKS-1:0][ADDR_W-1:0]    weight_SRAM_A_write,
    output logic [NUM_BANKS-1:0]                weight_SRAM_CEN_write,
    output logic [NUM_BANKS-1:0]                weight_SRAM_WEN
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    // Linear slot index (bank_start + word index); upper bits are the row offset.
    localparam int POS_W  = ADDR_W + BANK_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   rd_cnt;
    logic [ADDR_W-1:0]   last_idx;
    logic [ADDR_W-1:0]   buf_base;
    logic [ADDR_W-1:0]   sram_base;
    logic [BANK_W-1:0]   bank_base;
    logic                sel;

    logic                wr_valid;
    logic [POS_W-1:0]    wr_pos;

    logic [ADDR_W-1:0]   rd_addr;
    logic [BANK_W-1:0]   wr_bank;
    logic [ADDR_W-1:0]   wr_row;
    logic [DATA_W-1:0]   wr_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (buffer2sram_start) state_nxt = READ;
            READ:    if (rd_cnt == last_idx) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer parameters are captured once so the caller may retarget its
    // inputs while the copy is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt    <= '0;
            last_idx  <= '0;
            buf_base  <= '0;
            sram_base <= '0;
            bank_base <= '0;
            sel       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (buffer2sram_start) begin
                        rd_cnt    <= '0;
                        last_idx  <= BUF_ADDR_end - BUF_ADDR_start;
                        buf_base  <= BUF_ADDR_start;
                        sram_base <= SRAM_ADDR_start;
                        bank_base <= bank_start;
                        sel       <= buf_select;
                    end
                end
                READ:    rd_cnt <= rd_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // One-cycle write pipe matching the buffer read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_valid <= 1'b0;
            wr_pos   <= '0;
        end else begin
            wr_valid <= (state == READ);
            if (state == READ) begin
                wr_pos <= POS_W'(bank_base) + POS_W'(rd_cnt);
            end
        end
    end

    assign rd_addr = buf_base + rd_cnt;
    assign wr_bank = wr_pos[BANK_W-1:0];
    assign wr_row  = sram_base + wr_pos[POS_W-1:BANK_W];
    assign wr_data = wr_valid ? weight_buffer_DO[sel] : '0;

    always_comb begin
        weight_buffer_A_read   = '0;
        weight_buffer_CEN_read = '1;
        weight_buffer_OEN      = '1;
        case (state)
            READ: begin
                weight_buffer_A_read[sel]   = rd_addr;
                weight_buffer_CEN_read[sel] = 1'b0;
                weight_buffer_OEN[sel]      = 1'b0;
            end
            // Output enable held through the cycle the last word is written.
            DRAIN: weight_buffer_OEN[sel] = 1'b0;
            default: ;
        endcase
    end

    assign buffer2sram_done = (state == DONE);

    generate
        for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
            logic hit;
            assign hit                      = wr_valid && (wr_bank == BANK_W'(i));
            assign weight_SRAM_DI[i]        = wr_data;
            assign weight_SRAM_A_write[i]   = wr_valid ? wr_row : '0;
            assign weight_SRAM_CEN_write[i] = ~hit;
            assign weight_SRAM_WEN[i]       = ~hit;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_buffer2sram_weight.sv
// Bench for buffer2sram_weight: cycle-indexed transfer model plus directed checks.
`default_nettype none

module tb_buffer2sram_weight;

    logic              clk;
    logic              rst;
    logic [6:0]        bufs, bufe, sram_s;
    logic              bsel;
    logic [4:0]        bank_s;
    logic              start;
    logic              done;
    logic [1:0][287:0] buf_do;
    logic [1:0][6:0]   buf_a;
    logic [1:0]        cen_r, oen;
    logic [31:0][287:0] di;
    logic [31:0][6:0]  a_w;
    logic [31:0]       cen_w, wen;

    buffer2sram_weight dut (
        .clk                   (clk),
        .rst                   (rst),
        .BUF_ADDR_start        (bufs),
        .BUF_ADDR_end          (bufe),
        .buf_select            (bsel),
        .SRAM_ADDR_start       (sram_s),
        .bank_start            (bank_s),
        .buffer2sram_start     (start),
        .buffer2sram_done      (done),
        .weight_buffer_DO      (buf_do),
        .weight_buffer_A_read  (buf_a),
        .weight_buffer_CEN_read(cen_r),
        .weight_buffer_OEN     (oen),
        .weight_SRAM_DI        (di),
        .weight_SRAM_A_write   (a_w),
        .weight_SRAM_CEN_write (cen_w),
        .weight_SRAM_WEN       (wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Distinct content for every (buffer, address) pair.
    function automatic logic [287:0] pat(input logic b, input logic [6:0] a);
        logic [31:0]  w;
        logic [287:0] r;
        w = {a, b, 8'h5A, ~a, 9'h1A7};
        for (int k = 0; k < 9; k++) r[k*32 +: 32] = w ^ (32'(k) << 24);
        return r;
    endfunction

    // Buffer memories with one-cycle read latency.
    logic [1:0][6:0] a_l;
    logic [1:0]      cen_l;
    initial begin
        a_l = '0; cen_l = '1;
        buf_do[0] = {9{32'hDEAD0000}};
        buf_do[1] = {9{32'hBEEF0000}};
    end
    always @(negedge clk) begin
        a_l   = buf_a;
        cen_l = cen_r;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++)
            if (!cen_l[b]) buf_do[b] <= pat(b[0], a_l[b]);
    end

    // Transfer model: cycle c = edges since the accepting edge.
    int   ecnt = 0;
    int   m_t0 = 0;
    int   m_n = 0, m_bs = 0, m_sa = 0, m_bk = 0;
    logic m_sel = 1'b0;
    logic m_active = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
        end else begin
            if (start && (!m_active || (ecnt - m_t0) > m_n + 2)) begin
                m_bs     = int'(bufs);
                m_n      = (((int'(bufe) - int'(bufs)) % 128) + 128) % 128 + 1;
                m_sel    = bsel;
                m_sa     = int'(sram_s);
                m_bk     = int'(bank_s);
                m_t0     = ecnt;
                m_active = 1'b1;
            end
            ecnt++;
        end
    end

    always @(negedge clk) begin : cmp
        int          c, j, b;
        logic [1:0]  e_cen_r, e_oen;
        logic [31:0] e_cen_w;
        logic        e_done;
        e_cen_r = '1; e_oen = '1; e_cen_w = '1; e_done = 1'b0;
        if (m_active) begin
            c = ecnt - m_t0;
            if (c >= 1 && c <= m_n) begin
                e_cen_r[m_sel] = 1'b0;
                chk("read_addr", 288'(buf_a[m_sel]), 288'((m_bs + c - 1) % 128));
            end
            if (c >= 1 && c <= m_n + 1) e_oen[m_sel] = 1'b0;
            if (c >= 2 && c <= m_n + 1) begin
                j = c - 2;
                b = (m_bk + j) % 32;
                e_cen_w[b] = 1'b0;
                chk("write_addr", 288'(a_w[b]), 288'((m_sa + (m_bk + j) / 32) % 128));
                chk("write_data", di[b], pat(m_sel, 7'((m_bs + j) % 128)));
                chk("bcast_data", di[(b + 1) % 32], pat(m_sel, 7'((m_bs + j) % 128)));
            end
            e_done = (c == m_n + 2);
        end
        chk("cen_read", 288'(cen_r), 288'(e_cen_r));
        chk("oen", 288'(oen), 288'(e_oen));
        chk("cen_write", 288'(cen_w), 288'(e_cen_w));
        chk("wen", 288'(wen), 288'(e_cen_w));
        chk("done", 288'(done), 288'(e_done));
    end

    int wr_obs = 0;
    always @(negedge clk) if (rst) wr_obs += $countones(~cen_w);

    task automatic at_cycle(input int c);
        for (int k = 0; k < 300; k++) begin
            if (m_active && (ecnt - m_t0) == c) return;
            @(negedge clk);
        end
        chk("timeout", 288'(1), 288'(0));
    endtask

    task automatic go(input int bs, input int be, input int sel, input int sa, input int bk);
        @(negedge clk);
        bufs = 7'(bs); bufe = 7'(be); bsel = sel[0]; sram_s = 7'(sa); bank_s = 5'(bk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bufs = 7'($urandom); bufe = 7'($urandom); bsel = 1'($urandom);
        sram_s = 7'($urandom); bank_s = 5'($urandom);
    endtask

    int w0;

    initial begin
        rst = 1'b0; start = 1'b0;
        bufs = '0; bufe = '0; bsel = 1'b0; sram_s = '0; bank_s = '0;
        // Reset with random inputs, including start.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bufs = 7'($urandom); bufe = 7'($urandom); bsel = 1'($urandom);
            sram_s = 7'($urandom); bank_s = 5'($urandom); start = 1'($urandom);
        end
        #1;
        chk("rst_cen_write", 288'(cen_w), 288'(32'hFFFF_FFFF));
        chk("rst_cen_read", 288'(cen_r), 288'(2'b11));
        start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_done", 288'(done), 288'(0));

        // Basic transfer.
        go(0, 3, 0, 5, 0);
        at_cycle(2); #1;
        chk("t2_c2_cen", 288'(cen_w), 288'(32'hFFFF_FFFE));
        chk("t2_c2_addr", 288'(a_w[0]), 288'(5));
        at_cycle(5); #1;
        chk("t2_c5_cen", 288'(cen_w), 288'(32'hFFFF_FFF7));
        chk("t2_c5_done", 288'(done), 288'(0));
        at_cycle(6); #1;
        chk("t2_c6_done", 288'(done), 288'(1));

        // Bank wrap from buffer 1.
        w0 = wr_obs;
        go(10, 45, 1, 0, 30);
        at_cycle(2); #1;
        chk("t3_c2_cen", 288'(cen_w), 288'(32'hBFFF_FFFF));
        chk("t3_c2_addr", 288'(a_w[30]), 288'(0));
        at_cycle(4); #1;
        chk("t3_c4_cen", 288'(cen_w), 288'(32'hFFFF_FFFE));
        chk("t3_c4_addr", 288'(a_w[0]), 288'(1));
        at_cycle(37); #1;
        chk("t3_c37_cen", 288'(cen_w), 288'(32'hFFFF_FFFD));
        chk("t3_c37_addr", 288'(a_w[1]), 288'(2));
        chk("t3_c37_data", di[1], pat(1'b1, 7'd45));
        at_cycle(38); #1;
        chk("t3_done", 288'(done), 288'(1));
        chk("t3_writes", 288'(wr_obs - w0), 288'(36));

        // Buffer address wrap.
        go(126, 1, 0, 9, 3);
        at_cycle(1); #1;
        chk("t4_rd126", 288'(buf_a[0]), 288'(126));
        at_cycle(3); #1;
        chk("t4_rd0", 288'(buf_a[0]), 288'(0));
        at_cycle(6); #1;
        chk("t4_done", 288'(done), 288'(1));

        // Single word.
        go(7, 7, 1, 50, 12);
        at_cycle(2); #1;
        chk("t4s_cen", 288'(cen_w), 288'(32'hFFFF_EFFF));
        chk("t4s_addr", 288'(a_w[12]), 288'(50));
        at_cycle(3); #1;
        chk("t4s_done", 288'(done), 288'(1));

        // Busy start during READ and start coincident with done are ignored.
        w0 = wr_obs;
        go(40, 47, 0, 3, 5);
        at_cycle(3);
        bufs = 7'd90; bufe = 7'd100; bsel = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        at_cycle(10); #1;
        chk("t5_done", 288'(done), 288'(1));
        chk("t5_writes", 288'(wr_obs - w0), 288'(8));
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t5_no_restart", 288'(cen_r), 288'(2'b11));

        // Reset abort on write 2 of 8.
        go(20, 27, 1, 100, 31);
        at_cycle(3);
        #1 rst = 1'b0;
        #1;
        chk("abort_cen_write", 288'(cen_w), 288'(32'hFFFF_FFFF));
        chk("abort_cen_read", 288'(cen_r), 288'(2'b11));
        chk("abort_done", 288'(done), 288'(0));
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // Clean run after abort, wrapping bank and row.
        go(0, 2, 0, 126, 31);
        at_cycle(3); #1;
        chk("t6_addr", 288'(a_w[0]), 288'(127));
        at_cycle(5); #1;
        chk("t6_done", 288'(done), 288'(1));
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/buffer2sram_weight.md
Name: buffer2sram_weight

Overview:
- Copies a contiguous range of 288-bit kernel words from one of the two weight ping-pong buffers into the 32 weight SRAM banks.
- Sits between the DMA, which fills the weight buffers from DRAM, and the weight SRAM write mux, which feeds the controller.
- Started by transfer_controller with a range, a buffer select and a starting bank/address.
- Consecutive words are striped round-robin across banks, so kernel k lands in bank k mod 32.

Parameters:
NUM_BANKS, 32, number of weight SRAM banks
DATA_W, 288, weight word width (one 3x3 kernel of 32-bit values)
ADDR_W, 7, buffer and SRAM address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- BUF_ADDR_start  in  7  first buffer address to copy
- BUF_ADDR_end  in  7  last buffer address to copy (inclusive)
- buf_select  in  1  source weight buffer, 0 or 1
- SRAM_ADDR_start  in  7  SRAM row for the first word
- bank_start  in  5  bank for the first word
- buffer2sram_start  in  1  start pulse, sampled in IDLE only
- buffer2sram_done  out  1  one-cycle completion pulse
- weight_buffer_DO  in  2x288  buffer read data, one per buffer
- weight_buffer_A_read  out  2x7  buffer read address
- weight_buffer_CEN_read  out  2x1  buffer chip enable, active-low
- weight_buffer_OEN  out  2x1  buffer output enable, active-low
- weight_SRAM_DI  out  32x288  SRAM write data
- weight_SRAM_A_write  out  32x7  SRAM write address
- weight_SRAM_CEN_write  out  32x1  SRAM chip enable, active-low
- weight_SRAM_WEN  out  32x1  SRAM write enable, active-low

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, all counters 0, done=0.
  - All CEN/WEN/OEN outputs = 1. All addresses = 0, DI = 0.
- Word count: N = ((BUF_ADDR_end - BUF_ADDR_start) mod 128) + 1.
  - end < start wraps through 127 to 0.
  - end == start gives N=1.
  - All inputs are latched when start is accepted; later input changes are ignored.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 at an edge latches inputs; rd_cnt=0; go to READ.
  - READ: each cycle drive A_read[sel]=BUF_ADDR_start+rd_cnt (mod 128), CEN_read[sel]=0, OEN[sel]=0. The other buffer's CEN/OEN stay 1. rd_cnt++. After issuing word N-1, go to DRAIN.
  - DRAIN: buffer CEN=1, OEN kept 0 until the final write completes; go to DONE.
  - DONE: done=1 for exactly one cycle; return to IDLE.
- Write pipeline:
  - Buffer read latency is 1 cycle. A registered valid/index pipe follows each read by one cycle.
  - Word j read in cycle c is written in cycle c+1 to bank b=(bank_start+j) mod 32, address SRAM_ADDR_start+((bank_start+j) div 32) mod 128.
  - During that write, only CEN_write[b]=0 and WEN[b]=0; all other banks stay 1.
  - DI of every bank = weight_buffer_DO[sel] (broadcast).
- Timing: start sampled at edge 0 → first read cycle 1 → first write cycle 2 → last write cycle N+1 → done high in cycle N+2. Throughput is 1 word/cycle with no bubbles.
- Address overflow on buffer or SRAM address wraps mod 128 silently.
- start while not in IDLE is ignored; a start in the same cycle as done is ignored; start is honoured from the next IDLE cycle.
- Reset mid-transfer aborts immediately. No pending write is completed and done is not pulsed.
- The block never reads and writes the same buffer. The ping-pong ownership, via rw_select in transfer_controller, is the caller's responsibility.

Test Plan:
1. Reset: hold rst=0 with random inputs → all CEN/WEN/OEN=1, done=0. Release, with no start → outputs unchanged.
2. Basic transfer: buf_select=0, start=0, end=3, bank_start=0, SRAM_ADDR_start=5 → buffer0 words 0..3 written to banks 0..3 at address 5 in cycles 2..5. done pulses in cycle 6. Buffer1 CEN stays 1 throughout.
3. Bank wrap: buf_select=1, start=10, end=45, bank_start=30, SRAM_ADDR_start=0:
   - words 0,1 → banks 30,31 at address 0;
   - word 2 → bank 0 at address 1;
   - word 35 → bank 1 at address 2;
   - 36 writes total, done in cycle 38.
4. Buffer address wrap and single word:
   - start=126, end=1 → reads addresses 126,127,0,1 (N=4).
   - start=end=7 → one write, done in cycle 3.
5. Busy start and reset abort: pulse start during READ → ignored, with write count and done timing unchanged. Assert rst in the cycle of write 2 of 8 → outputs go inactive at once, no done. A new start after release runs cleanly.
